// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM decode, scoreboard and issue stage feeding the integer ALU
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  shamt,
    output logic [2:0]  insn_type,
    output logic [4:0]  rd,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        illegal_insn
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [31:0] regfile [32];
    logic [31:0] pending;

    logic [6:0]  dec_opcode;
    logic [2:0]  dec_f3;
    logic [6:0]  dec_f7;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        is_op_imm;
    logic        is_op;
    logic        legal;
    logic        wb_hit;
    logic [31:0] pend_eff;
    logic [31:0] pend_next;
    logic        hazard;
    logic        accept;
    logic        issue;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;

    assign dec_opcode = in_insn[6:0];
    assign dec_rd     = in_insn[11:7];
    assign dec_f3     = in_insn[14:12];
    assign dec_rs1    = in_insn[19:15];
    assign dec_rs2    = in_insn[24:20];
    assign dec_f7     = in_insn[31:25];
    assign is_op_imm  = (dec_opcode == OPC_OP_IMM);
    assign is_op      = (dec_opcode == OPC_OP);
    assign imm        = {{20{in_insn[31]}}, in_insn[31:20]};

    always_comb begin
        legal = 1'b0;
        if (is_op_imm) begin
            case (dec_f3)
                3'b001:  legal = (dec_f7 == F7_ZERO);
                3'b101:  legal = (dec_f7 == F7_ZERO) || (dec_f7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end else if (is_op) begin
            legal = (dec_f7 == F7_ZERO) ||
                    ((dec_f7 == F7_ALT) && ((dec_f3 == 3'b000) || (dec_f3 == 3'b101)));
        end
    end

    // A same-cycle writeback both forwards its data and releases the register for hazard purposes.
    assign wb_hit   = wb_en && (wb_rd != 5'd0);
    assign pend_eff = pending & ~(wb_hit ? (32'd1 << wb_rd) : 32'd0);

    assign rs1_val = (dec_rs1 == 5'd0) ? 32'd0 :
                     (wb_hit && (wb_rd == dec_rs1)) ? wb_data : regfile[dec_rs1];
    assign rs2_val = (dec_rs2 == 5'd0) ? 32'd0 :
                     (wb_hit && (wb_rd == dec_rs2)) ? wb_data : regfile[dec_rs2];

    // pending[0] is never set, so the rd check needs no explicit x0 guard.
    assign hazard   = legal && (pend_eff[dec_rs1] || (is_op && pend_eff[dec_rs2]) || pend_eff[dec_rd]);
    assign in_ready = (~out_valid | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;
    assign issue    = accept & legal;

    assign pend_next = pend_eff | ((issue && (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            illegal_insn <= 1'b0;
            op1          <= 32'd0;
            op2          <= 32'd0;
            funct3       <= 3'd0;
            funct7       <= 7'd0;
            shamt        <= 5'd0;
            insn_type    <= 3'd0;
            rd           <= 5'd0;
            pending      <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= 32'd0;
            end
        end else begin
            illegal_insn <= accept & ~legal;
            pending      <= pend_next;
            if (issue) begin
                out_valid <= 1'b1;
                op1       <= rs1_val;
                op2       <= is_op ? rs2_val : imm;
                funct3    <= dec_f3;
                funct7    <= dec_f7;
                shamt     <= dec_rs2;
                insn_type <= is_op ? 3'b001 : 3'b000;
                rd        <= dec_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (wb_hit) begin
                regfile[wb_rd] <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector table, async reset sequence and randomized model check of alu_issue_stage
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic [2:0]  insn_type;
    logic [4:0]  rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_insn;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .funct3(funct3),
        .funct7(funct7), .shamt(shamt), .insn_type(insn_type), .rd(rd), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .illegal_insn(illegal_insn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] insn;
        logic        iv;
        logic        ordy;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_valid;
        logic        e_ill;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        logic [4:0]  e_sh;
        logic [2:0]  e_type;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[13];

    // Reference model: architectural register values, pending set and the issued-instruction record.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid, m_ill;
    logic [31:0] m_op1, m_op2;
    logic [2:0]  m_f3, m_type;
    logic [6:0]  m_f7;
    logic [4:0]  m_sh, m_rd;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_valid = 0; m_ill = 0;
        m_op1 = 0; m_op2 = 0; m_f3 = 0; m_f7 = 0; m_sh = 0; m_type = 0; m_rd = 0;
    endtask

    function automatic bit m_legal(input logic [31:0] i);
        int opc = int'(i[6:0]);
        int f3  = int'(i[14:12]);
        int f7  = int'(i[31:25]);
        if (opc == 'h13) begin
            if (f3 == 1) return f7 == 0;
            if (f3 == 5) return (f7 == 0) || (f7 == 'h20);
            return 1;
        end
        if (opc == 'h33) return (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
        return 0;
    endfunction

    function automatic bit m_busy(input int r);
        return (r != 0) && m_pend[r] && !(wb_en && int'(wb_rd) == r);
    endfunction

    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return 32'd0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_ready();
        int  rs1 = int'(in_insn[19:15]);
        int  rs2 = int'(in_insn[24:20]);
        int  rdi = int'(in_insn[11:7]);
        bit  isop = (in_insn[6:0] == 7'h33);
        bit  hz = m_legal(in_insn) && (m_busy(rs1) || (isop && m_busy(rs2)) || m_busy(rdi));
        return (!m_valid || out_ready) && !hz;
    endfunction

    task automatic model_edge(input bit rdy);
        bit acc = in_valid && rdy;
        bit lg  = m_legal(in_insn);
        int rdi = int'(in_insn[11:7]);
        if (acc && lg) begin
            m_op1  = m_read(int'(in_insn[19:15]));
            m_op2  = (in_insn[6:0] == 7'h33) ? m_read(int'(in_insn[24:20]))
                                             : 32'(signed'(in_insn[31:20]));
            m_f3   = in_insn[14:12];
            m_f7   = in_insn[31:25];
            m_sh   = in_insn[24:20];
            m_type = (in_insn[6:0] == 7'h33) ? 3'd1 : 3'd0;
            m_rd   = in_insn[11:7];
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        m_ill = acc && !lg;
        if (wb_en && wb_rd != 0) begin
            m_regs[wb_rd] = wb_data;
            m_pend[wb_rd] = 0;
        end
        if (acc && lg && rdi != 0) m_pend[rdi] = 1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".illegal"}, 32'(illegal_insn), 32'(m_ill));
        chk({tag, ".op1"}, op1, m_op1);
        chk({tag, ".op2"}, op2, m_op2);
        chk({tag, ".funct3"}, 32'(funct3), 32'(m_f3));
        chk({tag, ".funct7"}, 32'(funct7), 32'(m_f7));
        chk({tag, ".shamt"}, 32'(shamt), 32'(m_sh));
        chk({tag, ".type"}, 32'(insn_type), 32'(m_type));
        chk({tag, ".rd"}, 32'(rd), 32'(m_rd));
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 1, 1, 0, 0, 0,            1, 1, 0, 0,            5,            0, 7'h00, 5,     0, 1};
        vecs[1]  = '{32'h00108133, 1, 1, 0, 0, 0,            0, 0, 0, 0,            5,            0, 7'h00, 5,     0, 1};
        vecs[2]  = '{32'h00108133, 1, 1, 1, 1, 5,            1, 1, 0, 5,            5,            0, 7'h00, 1,     1, 2};
        vecs[3]  = '{32'hFFF00193, 1, 1, 0, 0, 0,            1, 1, 0, 0,            32'hFFFFFFFF, 0, 7'h7F, 5'h1F, 0, 3};
        vecs[4]  = '{32'h4041D213, 1, 1, 1, 3, 32'hFFFFFFFF, 1, 1, 0, 32'hFFFFFFFF, 32'h404,      5, 7'h20, 4,     0, 4};
        vecs[5]  = '{32'h00100293, 1, 0, 0, 0, 0,            0, 1, 0, 32'hFFFFFFFF, 32'h404,      5, 7'h20, 4,     0, 4};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = '{32'h00100293, 1, 1, 0, 0, 0,            1, 1, 0, 0,            1,            0, 7'h00, 1,     0, 5};
        vecs[9]  = '{32'h00700093, 1, 1, 0, 0, 0,            1, 1, 0, 0,            7,            0, 7'h00, 7,     0, 1};
        vecs[10] = '{32'h00000003, 1, 1, 0, 0, 0,            1, 0, 1, 0,            7,            0, 7'h00, 7,     0, 1};
        vecs[11] = '{32'h02208033, 1, 1, 0, 0, 0,            1, 0, 1, 0,            7,            0, 7'h00, 7,     0, 1};
        vecs[12] = '{32'h00000000, 0, 1, 0, 0, 0,            1, 0, 0, 0,            7,            0, 7'h00, 7,     0, 1};

        rst = 1; in_valid = 0; in_insn = 0; out_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0;
        #2;
        chk("reset.out_valid", 32'(out_valid), 0);
        chk("reset.illegal", 32'(illegal_insn), 0);
        chk("reset.op1", op1, 0);
        chk("reset.op2", op2, 0);
        chk("reset.rd", 32'(rd), 0);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 13; i++) begin
            in_insn = vecs[i].insn; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
            wb_en = vecs[i].we; wb_rd = vecs[i].wr; wb_data = vecs[i].wd;
            #3;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.illegal", i), 32'(illegal_insn), 32'(vecs[i].e_ill));
            chk($sformatf("vec%0d.op1", i), op1, vecs[i].e_op1);
            chk($sformatf("vec%0d.op2", i), op2, vecs[i].e_op2);
            chk($sformatf("vec%0d.funct3", i), 32'(funct3), 32'(vecs[i].e_f3));
            chk($sformatf("vec%0d.funct7", i), 32'(funct7), 32'(vecs[i].e_f7));
            chk($sformatf("vec%0d.shamt", i), 32'(shamt), 32'(vecs[i].e_sh));
            chk($sformatf("vec%0d.type", i), 32'(insn_type), 32'(vecs[i].e_type));
            chk($sformatf("vec%0d.rd", i), 32'(rd), 32'(vecs[i].e_rd));
        end

        // Asynchronous reset mid-cycle while x1/x2 are pending and an instruction is held on the outputs.
        in_insn = 32'h00300393; in_valid = 1; out_ready = 1; wb_en = 0;
        @(posedge clk); #1;
        chk("arst.pre_valid", 32'(out_valid), 1);
        in_valid = 0; out_ready = 0;
        #2 rst = 1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 0);
        chk("arst.op1", op1, 0);
        in_insn = 32'h00108133; in_valid = 1; out_ready = 1;
        #1;
        chk("arst.in_ready", 32'(in_ready), 1);
        rst = 0;
        @(posedge clk); #1;
        chk("arst.add_valid", 32'(out_valid), 1);
        chk("arst.add_op1", op1, 0);
        chk("arst.add_op2", op2, 0);
        chk("arst.add_type", 32'(insn_type), 1);
        chk("arst.add_rd", 32'(rd), 2);

        rst = 1; in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();

        for (int n = 0; n < 2000; n++) begin
            logic [6:0] opc;
            logic [6:0] f7;
            bit         r;
            case ($urandom_range(0, 3))
                0:       opc = 7'h13;
                1, 2:    opc = 7'h33;
                default: opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            in_insn = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                       5'($urandom_range(0, 7)), opc};
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            #3;
            r = m_ready();
            chk("rand.in_ready", 32'(in_ready), 32'(r));
            @(posedge clk);
            model_edge(r);
            #1;
            check_outputs("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that feeds the RV32I integer ALU. It accepts raw 32-bit instruction words and decodes OP-IMM and OP instructions. It reads operands from an internal 32x32 register file, tracks outstanding destination registers with a scoreboard, and presents registered operands and decoded fields to the ALU over a valid/ready handshake. ALU results return through a writeback port that updates the register file and clears the scoreboard.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous and active-high.
- in_valid  in  1  in_insn holds a valid instruction.
- in_ready  out  1  stage accepts in_insn this cycle.
- in_insn  in  32  RV32I instruction word.
- out_valid  out  1  ALU-side outputs hold an issued instruction.
- out_ready  in  1  ALU consumes the issued instruction this cycle.
- op1  out  32  value of rs1.
- op2  out  32  OP: value of rs2. OP-IMM: insn[31:20] sign-extended to 32 bits.
- funct3  out  3  insn[14:12].
- funct7  out  7  insn[31:25].
- shamt  out  5  insn[24:20].
- insn_type  out  3  3'b000 = OP-IMM (opcode 0010011); 3'b001 = OP (opcode 0110011).
- rd  out  5  destination register of the issued instruction.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback register index.
- wb_data  in  32  writeback value.
- illegal_insn  out  1  one-cycle pulse when an illegal instruction is accepted.

## Operation
- Reset values: out_valid=0, illegal_insn=0, and op1/op2/funct3/funct7/shamt/insn_type/rd all 0. All 32 register-file entries are cleared to 0 and all pending bits are cleared.
- Register file:
  - x0 always reads 0.
  - A writeback with wb_rd=0 is ignored and leaves pending state untouched.
  - When wb_en=1 and wb_rd≠0, regfile[wb_rd] is written with wb_data and pending[wb_rd] is cleared.
- Forwarding: when wb_en=1 and wb_rd matches a source register in the same cycle, that operand takes wb_data, and the register counts as not pending for the hazard check.
- Legality rules:
  - OP-IMM with funct3 001 requires funct7=0000000.
  - OP-IMM with funct3 101 requires funct7 of 0000000 or 0100000.
  - OP requires funct7=0000000, or funct7=0100000 with funct3 000 or 101.
  - Every other opcode or funct7 combination is illegal.
- Hazard: a legal instruction stalls while any of the following registers is pending, after the same-cycle writeback clear is applied:
  - rs1;
  - rs2, for OP only;
  - rd, if rd≠0 (WAW).
  - Illegal instructions never stall on hazards.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hazard.
  - An instruction is accepted when in_valid & in_ready.
- On accepting a legal instruction:
  - The output register loads the decoded fields and operands, and out_valid is set to 1.
  - If rd≠0, pending[rd] is set. Set takes priority over a same-cycle writeback clear of the same index.
- On accepting an illegal instruction: the output register is not loaded, illegal_insn is 1 in the next cycle, and the instruction is dropped.
- out_valid behaviour:
  - Clears when out_ready=1 and no legal instruction is accepted in the same cycle.
  - While out_valid=1 and out_ready=0, all outputs hold stable.

## Timing
- Issue latency is 1 cycle: an instruction accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1.
- Back-to-back issue, one instruction per cycle, is sustained when out_ready=1 and there are no hazards.
- A writeback in cycle N is visible to an issue in the same cycle N through forwarding, and in the register file from N+1.
- A stall releases in the cycle in which the matching writeback arrives.
- in_ready and hazard are combinational from in_insn, pending, the writeback inputs and out_ready. They have no path from out_valid to out_ready, or the reverse.
- Asserting rst mid-operation immediately clears out_valid, illegal_insn, pending and the register file, independent of clk. Any instruction in flight is discarded.

## Test plan
- Reset, then in_insn=0x00500093 (ADDI x1,x0,5) with out_ready=1 → next cycle out_valid=1, op1=0, op2=5, funct3=000, insn_type=000, rd=1, and pending[1]=1.
- Continuing from the previous case, in_insn=0x00108133 (ADD x2,x1,x1) → in_ready=0 until wb_en=1, wb_rd=1, wb_data=5. It is accepted in that same cycle, and the next cycle shows op1=op2=5, insn_type=001.
- 0xFFF00193 (ADDI x3,x0,-1) → op2=0xFFFFFFFF. After writeback of x3, 0x4041D213 (SRAI x4,x3,4) → funct7=0100000, shamt=4, funct3=101, op2=0x00000404.
- Issue one instruction, then hold out_ready=0 for 3 cycles → outputs stay stable and in_ready=0. On out_ready=1, the held instruction is consumed and the next one is accepted in the same cycle.
- 0x00000003 (load) → illegal_insn pulses for 1 cycle and out_valid stays 0. 0x02208033 (MUL) → illegal_insn pulses and it does not stall even with x1 pending.
- Assert rst asynchronously between clock edges while x1 is pending and out_valid=1 → out_valid=0 and pending cleared immediately. After release, ADD x2,x1,x1 issues with no stall and op1=op2=0.
